// File: rtl/nn_config_loader.sv
// Transmit side of the neuron configuration bus: parses header/payload words from a
// ready/valid stream and broadcasts weight/bias strobes with the addressed layer/neuron.
module nn_config_loader #(
   parameter int maxCount   = 784,
   parameter int countWidth = 14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        weightValid,
   output logic [31:0] weightValue,
   output logic        biasValid,
   output logic [31:0] biasValue,
   output logic [31:0] config_layer_num,
   output logic [31:0] config_neuron_num,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FIN} state_t;

   localparam logic [1:0]            KIND_WEIGHT = 2'b01;
   localparam logic [1:0]            KIND_BIAS   = 2'b10;
   localparam logic [countWidth-1:0] MAX_CNT     = countWidth'(maxCount);
   localparam logic [countWidth-1:0] ONE_CNT     = countWidth'(1);

   state_t                  state, state_nxt;
   logic [1:0]              kind;
   logic [countWidth-1:0]   cnt;
   logic                    accept;
   logic [1:0]              hdr_kind;
   logic [countWidth-1:0]   hdr_count;
   logic                    hdr_ok;

   assign accept    = s_valid && s_ready;
   assign hdr_kind  = s_data[31:30];
   assign hdr_count = s_data[16 +: countWidth];
   assign hdr_ok    = ((hdr_kind == KIND_WEIGHT) || (hdr_kind == KIND_BIAS)) &&
                      (hdr_count <= MAX_CNT);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FIN holds s_ready low for one cycle so config_* can never move alongside a strobe
   always_comb begin
      state_nxt = state;
      s_ready   = (state != FIN);
      busy      = (state != IDLE);
      done      = (state == FIN);
      case (state)
         IDLE: begin
            if (accept) begin
               if (hdr_count == '0) state_nxt = FIN;
               else if (hdr_ok)     state_nxt = LOAD;
               else                 state_nxt = DRAIN;
            end
         end
         LOAD, DRAIN: begin
            if (accept && (cnt == ONE_CNT)) state_nxt = FIN;
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         kind              <= '0;
         cnt               <= '0;
         weightValid       <= 1'b0;
         weightValue       <= '0;
         biasValid         <= 1'b0;
         biasValue         <= '0;
         config_layer_num  <= '0;
         config_neuron_num <= '0;
         err               <= 1'b0;
      end else begin
         weightValid <= 1'b0;
         biasValid   <= 1'b0;
         if (accept) begin
            case (state)
               IDLE: begin
                  kind              <= hdr_kind;
                  cnt               <= hdr_count;
                  config_layer_num  <= {24'd0, s_data[15:8]};
                  config_neuron_num <= {24'd0, s_data[7:0]};
                  if (!hdr_ok) err <= 1'b1;
               end
               LOAD: begin
                  cnt <= cnt - ONE_CNT;
                  if (kind == KIND_WEIGHT) begin
                     weightValue <= s_data;
                     weightValid <= 1'b1;
                  end else begin
                     biasValue <= s_data;
                     biasValid <= 1'b1;
                  end
               end
               DRAIN:   cnt <= cnt - ONE_CNT;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_nn_config_loader.sv
// Self-checking bench for nn_config_loader: directed records plus randomized streams,
// compared every cycle against a stream-parsing reference model.
module tb_nn_config_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready, weightValid, biasValid, busy, done, err;
   logic [31:0] weightValue, biasValue, config_layer_num, config_neuron_num;

   always #5 clk = ~clk;

   nn_config_loader dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .weightValid(weightValid), .weightValue(weightValue),
      .biasValid(biasValid), .biasValue(biasValue),
      .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
      .busy(busy), .done(done), .err(err)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // inputs as seen at the most recent rising edge
   logic        smp_rst = 1'b1;
   logic        smp_valid = 1'b0;
   logic [31:0] smp_data = '0;

   always @(posedge clk) begin
      smp_rst   <= rst;
      smp_valid <= s_valid;
      smp_data  <= s_data;
   end

   // reference model: walks the accepted word stream record by record
   int          rem = 0;
   logic        fwd = 1'b0;
   logic [1:0]  mkind = '0;
   logic        m_wv = 0, m_bv = 0, m_done = 0, m_err = 0, m_ready = 1, m_busy = 0;
   logic [31:0] m_wval = '0, m_bval = '0, m_layer = '0, m_neuron = '0;
   int          wstrobes = 0, bstrobes = 0, dones = 0;

   task automatic model_step();
      logic acc;
      int   c;
      if (smp_rst) begin
         rem = 0; fwd = 0; mkind = '0;
         m_wv = 0; m_bv = 0; m_done = 0; m_err = 0; m_ready = 1; m_busy = 0;
         m_wval = '0; m_bval = '0; m_layer = '0; m_neuron = '0;
         return;
      end
      acc    = smp_valid && m_ready;
      m_wv   = 0;
      m_bv   = 0;
      m_done = 0;
      if (acc) begin
         if (rem == 0) begin
            mkind    = smp_data[31:30];
            c        = int'(smp_data[29:16]);
            m_layer  = {24'd0, smp_data[15:8]};
            m_neuron = {24'd0, smp_data[7:0]};
            fwd      = ((mkind == 2'b01) || (mkind == 2'b10)) && (c <= 784);
            if (!fwd) m_err = 1;
            rem = c;
            if (c == 0) m_done = 1;
         end else begin
            rem--;
            if (fwd) begin
               if (mkind == 2'b01) begin m_wv = 1; m_wval = smp_data; end
               else begin m_bv = 1; m_bval = smp_data; end
            end
            if (rem == 0) m_done = 1;
         end
      end
      m_ready = !m_done;
      m_busy  = (rem != 0) || m_done;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         model_step();
         chk("s_ready", s_ready, m_ready);
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("err", err, m_err);
         chk("weightValid", weightValid, m_wv);
         chk("biasValid", biasValid, m_bv);
         chk("weightValue", weightValue, m_wval);
         chk("biasValue", biasValue, m_bval);
         chk("layer", config_layer_num, m_layer);
         chk("neuron", config_neuron_num, m_neuron);
         if (weightValid) wstrobes++;
         if (biasValid)   bstrobes++;
         if (done)        dones++;
      end
   end

   // called at a negedge; returns at the negedge following the accepting edge
   task automatic put(input logic [31:0] w, input int gap);
      int n;
      repeat (gap) begin
         s_valid = 1'b0;
         @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = w;
      n = 0;
      while (!s_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("ready_timeout", 32'd1, 32'd0);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      s_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic clr_counts();
      wstrobes = 0;
      bstrobes = 0;
      dones    = 0;
   endtask

   initial begin
      int k, cnt, nw;
      logic [1:0] kd;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_ready", s_ready, 1);
      chk("reset_busy", busy, 0);

      // weights 0xA,0xB,0xC to layer 1 neuron 2, back to back
      clr_counts();
      put(32'h4003_0102, 0); put(32'hA, 0); put(32'hB, 0); put(32'hC, 0);
      idle(3);
      chk("t1_wstrobes", wstrobes, 3);
      chk("t1_dones", dones, 1);
      chk("t1_layer", config_layer_num, 1);
      chk("t1_neuron", config_neuron_num, 2);

      // single bias word
      clr_counts();
      put(32'h8001_0005, 0); put(32'h0000_00F0, 0);
      idle(3);
      chk("t2_bstrobes", bstrobes, 1);
      chk("t2_wstrobes", wstrobes, 0);
      chk("t2_bias", biasValue, 32'hF0);

      // stalled every other cycle
      clr_counts();
      put(32'h4004_0307, 1);
      for (int i = 0; i < 4; i++) put($urandom, 1);
      idle(3);
      chk("t3_wstrobes", wstrobes, 4);
      chk("t3_dones", dones, 1);

      // illegal kind drains, then a legal record still loads
      clr_counts();
      put(32'hC002_0000, 0); put($urandom, 0); put($urandom, 0);
      idle(3);
      chk("t4_strobes", wstrobes + bstrobes, 0);
      chk("t4_dones", dones, 1);
      chk("t4_err", err, 1);
      clr_counts();
      put(32'h4002_0203, 0); put($urandom, 0); put($urandom, 0);
      idle(3);
      chk("t4b_wstrobes", wstrobes, 2);
      chk("t4b_err", err, 1);

      // oversize count drained; then zero count
      do_reset();
      chk("t5_err_clear", err, 0);
      clr_counts();
      put(32'h4311_0000, 0);
      for (int i = 0; i < 785; i++) put($urandom, 0);
      idle(3);
      chk("t5_strobes", wstrobes + bstrobes, 0);
      chk("t5_dones", dones, 1);
      chk("t5_err", err, 1);
      clr_counts();
      put(32'h4000_0108, 0);
      idle(3);
      chk("t5b_dones", dones, 1);
      chk("t5b_strobes", wstrobes + bstrobes, 0);

      // reset in the middle of a record
      do_reset();
      clr_counts();
      put(32'h4005_0401, 0); put($urandom, 0); put($urandom, 0);
      do_reset();
      idle(3);
      chk("t6_wstrobes", wstrobes, 2);
      chk("t6_dones", dones, 0);
      chk("t6_busy", busy, 0);
      chk("t6_layer", config_layer_num, 0);
      clr_counts();
      put(32'h4001_0009, 0); put(32'h55, 0);
      idle(3);
      chk("t6b_wstrobes", wstrobes, 1);
      chk("t6b_neuron", config_neuron_num, 9);
      chk("t6b_weight", weightValue, 32'h55);

      // randomized records
      for (int r = 0; r < 60; r++) begin
         k = $urandom_range(0, 9);
         kd = (k < 4) ? 2'b01 : (k < 8) ? 2'b10 : (k == 8) ? 2'b00 : 2'b11;
         k = $urandom_range(0, 19);
         if (k == 0)       cnt = 0;
         else if (k == 19) cnt = $urandom_range(785, 800);
         else if (k == 18) cnt = 784;
         else              cnt = $urandom_range(1, 6);
         put({kd, 14'(cnt), 8'($urandom), 8'($urandom)}, $urandom_range(0, 1));
         nw = cnt;
         if ($urandom_range(0, 19) == 0 && cnt > 1) nw = cnt / 2;
         for (int i = 0; i < nw; i++)
            put($urandom, ($urandom_range(0, 3) == 0) ? 1 : 0);
         if (nw != cnt) do_reset();
         else if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
      end
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
